// File: rtl/async_fifo_pkg.sv
// Shared definitions for both sides of the asynchronous FIFO: default address
// width and Gray/binary conversion helpers.
package async_fifo_pkg;

   localparam int ADDRSIZE_DEF = 4;

   // Helpers work on up to 32-bit pointers; bits at and above w are ignored.
   function automatic logic [31:0] bin2gray(input logic [31:0] b, input int unsigned w);
      logic [31:0] m;
      m = 32'((64'(1) << w) - 64'(1));
      return (b & m) ^ ((b & m) >> 1);
   endfunction

   function automatic logic [31:0] gray2bin(input logic [31:0] g, input int unsigned w);
      logic [31:0] b;
      b = g & 32'((64'(1) << w) - 64'(1));
      for (int s = 1; s < 32; s = s << 1) begin
         b = b ^ (b >> s);
      end
      return b;
   endfunction

endpackage

// File: rtl/gray2bin_conv.sv
// Combinational Gray-to-binary converter: each binary bit is the XOR of all
// Gray bits at or above its position.
module gray2bin_conv #(
   parameter int W = 5
) (
   input  logic [W-1:0] gray,
   output logic [W-1:0] bin
);

   always_comb begin
      bin = '0;
      bin[W-1] = gray[W-1];
      for (int i = W - 2; i >= 0; i--) begin
         bin[i] = bin[i+1] ^ gray[i];
      end
   end

endmodule

// File: rtl/rptr_empty_ctrl.sv
// Read-side pointer and status controller of the asynchronous FIFO: owns the
// read pointer, memory address and empty/almost-empty/occupancy/underflow status.
module rptr_empty_ctrl
   import async_fifo_pkg::*;
#(
   parameter int ADDRSIZE      = ADDRSIZE_DEF,
   parameter int AEMPTY_THRESH = 2
) (
   input  logic                rclk,
   input  logic                rrst,
   input  logic                rinc,
   input  logic [ADDRSIZE:0]   rq2_wptr,
   output logic [ADDRSIZE-1:0] raddr,
   output logic [ADDRSIZE:0]   rptr,
   output logic                rempty,
   output logic                raempty,
   output logic [ADDRSIZE:0]   rcount,
   output logic                runderflow
);

   localparam int PW = ADDRSIZE + 1;
   localparam logic [PW-1:0] AE_THRESH = PW'(AEMPTY_THRESH);

   logic [PW-1:0] rbin_q, rbin_d;
   logic [PW-1:0] rptr_q, rptr_d;
   logic [PW-1:0] rcount_q, rcount_d;
   logic          rempty_q, rempty_d;
   logic          raempty_q, raempty_d;
   logic          runderflow_q, runderflow_d;

   logic          rpop;
   logic [PW-1:0] rbinnext, rgraynext, wbin, countnext;

   gray2bin_conv #(.W(PW)) u_wptr_g2b (
      .gray (rq2_wptr),
      .bin  (wbin)
   );

   // Status compares against the next pointer so a pop of the last word
   // raises rempty at the same edge, with no bubble.
   always_comb begin
      rpop         = rinc & ~rempty_q;
      rbinnext     = rbin_q + {{ADDRSIZE{1'b0}}, rpop};
      rgraynext    = PW'(bin2gray(32'(rbinnext), PW));
      countnext    = wbin - rbinnext;
      rbin_d       = rbinnext;
      rptr_d       = rgraynext;
      rempty_d     = (rgraynext == rq2_wptr);
      rcount_d     = countnext;
      raempty_d    = (countnext <= AE_THRESH);
      runderflow_d = runderflow_q | (rinc & rempty_q);
   end

   always_ff @(posedge rclk) begin
      if (rrst) begin
         rbin_q       <= '0;
         rptr_q       <= '0;
         rcount_q     <= '0;
         rempty_q     <= 1'b1;
         raempty_q    <= 1'b1;
         runderflow_q <= 1'b0;
      end else begin
         rbin_q       <= rbin_d;
         rptr_q       <= rptr_d;
         rcount_q     <= rcount_d;
         rempty_q     <= rempty_d;
         raempty_q    <= raempty_d;
         runderflow_q <= runderflow_d;
      end
   end

   assign raddr      = rbin_q[ADDRSIZE-1:0];
   assign rptr       = rptr_q;
   assign rempty     = rempty_q;
   assign raempty    = raempty_q;
   assign rcount     = rcount_q;
   assign runderflow = runderflow_q;

endmodule
